// File: rtl/seq_alu.sv
// Registered ALU with a valid/ready operand handshake.
// Single-cycle logic/arith ops plus an iterative shift-add multiplier.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE,
        BUSY
    } stateT;

    stateT state;

    logic [2*WIDTH-1:0] mulAcc;
    logic [2*WIDTH-1:0] mulMcand;
    logic [WIDTH-1:0]   mulMplier;
    logic [CW-1:0]      stepCnt;
    logic [2*WIDTH-1:0] accNext;
    logic               lastStep;

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   subSum;
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;
    logic             aluOvf;
    logic             sltBit;
    logic             msbA;
    logic             msbB;

    assign in_ready = (state == IDLE);

    // Subtraction as A + ~B + 1: the top bit is the no-borrow flag.
    assign addSum = {1'b0, inA} + {1'b0, inB};
    assign subSum = {1'b0, inA} + {1'b0, ~inB} + (WIDTH+1)'(1);
    assign sltBit = $signed(inA) < $signed(inB);
    assign msbA   = inA[WIDTH-1];
    assign msbB   = inB[WIDTH-1];

    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        unique case (op)
            OP_AND: aluRes = inA & inB;
            OP_OR:  aluRes = inA | inB;
            OP_XOR: aluRes = inA ^ inB;
            OP_ADD: begin
                aluRes   = addSum[WIDTH-1:0];
                aluCarry = addSum[WIDTH];
                aluOvf   = (msbA == msbB) &&
                           (addSum[WIDTH-1] != msbA);
            end
            OP_SUB: begin
                aluRes   = subSum[WIDTH-1:0];
                aluCarry = subSum[WIDTH];
                aluOvf   = (msbA != msbB) &&
                           (subSum[WIDTH-1] != msbA);
            end
            OP_SLT: aluRes = {{(WIDTH-1){1'b0}}, sltBit};
            OP_SRL: aluRes = inA >> inB[SW-1:0];
            OP_MUL: aluRes = '0;
        endcase
    end

    assign accNext  = mulAcc + (mulMplier[0] ? mulMcand : '0);
    assign lastStep = (stepCnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mulAcc     <= '0;
            mulMcand   <= '0;
            mulMplier  <= '0;
            stepCnt    <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            result_hi  <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && op == OP_MUL) begin
                        mulMcand  <= {{WIDTH{1'b0}}, inA};
                        mulMplier <= inB;
                        mulAcc    <= '0;
                        stepCnt   <= '0;
                        state     <= BUSY;
                    end else if (in_valid) begin
                        result     <= aluRes;
                        result_hi  <= '0;
                        flag_zero  <= (aluRes == '0);
                        flag_carry <= aluCarry;
                        flag_ovf   <= aluOvf;
                        out_valid  <= 1'b1;
                    end
                end
                BUSY: begin
                    mulAcc    <= accNext;
                    mulMcand  <= mulMcand << 1;
                    mulMplier <= mulMplier >> 1;
                    stepCnt   <= stepCnt + CW'(1);
                    if (lastStep) begin
                        result     <= accNext[WIDTH-1:0];
                        result_hi  <= accNext[2*WIDTH-1:WIDTH];
                        flag_zero  <= (accNext == '0);
                        flag_carry <= 1'b0;
                        flag_ovf   <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8).
// Driver pushes expected results; a negedge monitor pops on out_valid.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic [2:0]   op;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
    } expT;

    expT sbq[$];
    int  tests = 0;
    int  fails = 0;
    int  pulses = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inA        (inA),
        .inB        (inB),
        .op         (op),
        .out_valid  (out_valid),
        .result     (result),
        .result_hi  (result_hi),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            expT got;
            expT e;
            got = '{result, result_hi, flag_zero, flag_carry, flag_ovf};
            pulses++;
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected out_valid got=%h", got);
            end else begin
                e = sbq.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL scoreboard got res=%h hi=%h zcv=%b%b%b want res=%h hi=%h zcv=%b%b%b",
                             got.res, got.hi, got.z, got.c, got.v,
                             e.res, e.hi, e.z, e.c, e.v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input expT e,
                        input bit push);
        int n;
        in_valid = 1'b1;
        op = o;
        inA = a;
        inB = b;
        if (push) sbq.push_back(e);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout in_ready=0");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic expT mk(input logic [W-1:0] r, input logic [W-1:0] h,
                               input logic z, input logic c, input logic v);
        mk = '{r, h, z, c, v};
    endfunction

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        inA = '0;
        inB = '0;
        op = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'h0);
        check("rst_hi", 32'(result_hi), 32'h0);
        check("rst_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // add/sub/slt
        send(3'b011, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1, 1, 0), 1);
        send(3'b011, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 0, 1), 1);
        send(3'b100, 8'h05, 8'h07, mk(8'hFE, 8'h00, 0, 0, 0), 1);
        send(3'b100, 8'h80, 8'h01, mk(8'h7F, 8'h00, 0, 1, 1), 1);
        send(3'b101, 8'h80, 8'h01, mk(8'h01, 8'h00, 0, 0, 0), 1);
        send(3'b101, 8'h01, 8'h80, mk(8'h00, 8'h00, 1, 0, 0), 1);
        send(3'b110, 8'hA5, 8'h08, mk(8'hA5, 8'h00, 0, 0, 0), 1);
        idle(2);

        // back-to-back
        n = pulses;
        send(3'b000, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0), 1);
        check("b2b_pulse0", 32'(out_valid), 32'h1);
        send(3'b001, 8'hF0, 8'h3C, mk(8'hFC, 8'h00, 0, 0, 0), 1);
        check("b2b_pulse1", 32'(out_valid), 32'h1);
        send(3'b010, 8'hF0, 8'h3C, mk(8'hCC, 8'h00, 0, 0, 0), 1);
        check("b2b_pulse2", 32'(out_valid), 32'h1);
        send(3'b110, 8'h80, 8'h0B, mk(8'h10, 8'h00, 0, 0, 0), 1);
        check("b2b_pulse3", 32'(out_valid), 32'h1);
        idle(2);
        check("b2b_count", 32'(pulses - n), 32'd4);

        // MUL 0xFF*0xFF with operand churn while busy
        send(3'b111, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 0, 0), 1);
        for (int i = 0; i < W; i++) begin
            check("mul_busy_ready", 32'(in_ready), 32'h0);
            check("mul_busy_valid", 32'(out_valid), 32'h0);
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 6));
            inA = 8'($urandom);
            inB = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mul_done_valid", 32'(out_valid), 32'h1);
        check("mul_done_ready", 32'(in_ready), 32'h1);
        idle(2);

        // reset in the middle of a MUL
        send(3'b111, 8'h0F, 8'h0F, mk(8'h00, 8'h00, 0, 0, 0), 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_result", 32'(result), 32'h0);
        check("abort_hi", 32'(result_hi), 32'h0);
        check("abort_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'h0);
        check("abort_valid", 32'(out_valid), 32'h0);
        check("abort_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        n = pulses;
        idle(12);
        check("abort_no_pulse", 32'(pulses - n), 32'd0);
        send(3'b011, 8'h02, 8'h03, mk(8'h05, 8'h00, 0, 0, 0), 1);
        check("post_reset_valid", 32'(out_valid), 32'h1);
        idle(1);

        // MUL by zero, then an op issued in the out_valid cycle
        send(3'b111, 8'h00, 8'hAB, mk(8'h00, 8'h00, 1, 0, 0), 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mul0_done", 32'(out_valid), 32'h1);
        send(3'b011, 8'h10, 8'h20, mk(8'h30, 8'h00, 0, 0, 0), 1);
        check("follow_valid", 32'(out_valid), 32'h1);
        idle(4);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
